// File: rtl/usbfs_pkg.sv
// Shared USB full-speed TX definitions: PID codes, TX state encoding and CRC16 constants.
package usbfs_pkg;

  localparam logic [3:0] PidAck   = 4'h2;
  localparam logic [3:0] PidNak   = 4'hA;
  localparam logic [3:0] PidStall = 4'hE;
  localparam logic [3:0] PidData0 = 4'h3;
  localparam logic [3:0] PidData1 = 4'hB;

  localparam logic [7:0]  SyncByte     = 8'h80;
  localparam logic [15:0] Crc16Init    = 16'hFFFF;
  localparam logic [15:0] Crc16Poly    = 16'h8005;
  // Bit-reversed form of Crc16Poly for the LSB-first shift register.
  localparam logic [15:0] Crc16PolyRef = 16'hA001;

  typedef enum logic [2:0] {
    StIdle,
    StSync,
    StPid,
    StReq,
    StWait,
    StData,
    StCrcL,
    StCrcH
  } tx_state_e;

  // Only DATA0/DATA1 carry a payload and a CRC16 trailer.
  function automatic logic is_data_pid(input logic [3:0] pid);
    return (pid == PidData0) || (pid == PidData1);
  endfunction

endpackage

// File: rtl/usbfs_crc16.sv
// Combinational byte-wise CRC16-USB update (reflected, data bits consumed LSB first).
module usbfs_crc16
  import usbfs_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  byte_in,
  output logic [15:0] crc_out
);

  logic [15:0] crc_acc;

  // Eight serial steps of the reflected LFSR unrolled into one cycle.
  always_comb begin
    crc_acc = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (crc_acc[0] ^ byte_in[i]) begin
        crc_acc = (crc_acc >> 1) ^ Crc16PolyRef;
      end else begin
        crc_acc = crc_acc >> 1;
      end
    end
    crc_out = crc_acc;
  end

endmodule

// File: rtl/usbfs_packet_tx.sv
// USB full-speed packet transmitter: frames handshake and DATA packets into a byte stream
// (optional SYNC, PID, payload, CRC16) for the bit-level layer.
// Build option: define USBFS_TX_SYNC_EN to emit the 8'h80 SYNC byte here; otherwise the
// bit layer prepends SYNC and the first byte out is the PID.
module usbfs_packet_tx #(
  parameter logic [9:0] MAX_DATA_LEN = 10'd1023
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       tp_sta,
  input  logic [3:0] tp_pid,
  output logic       tp_byte_req,
  input  logic [7:0] tp_byte,
  input  logic       tp_fin_n,
  output logic [7:0] tx_byte,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       tx_last,
  output logic       tx_busy
);
  import usbfs_pkg::*;

  tx_state_e   state_q, state_d;
  logic [3:0]  pid_q, pid_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [15:0] crc_q, crc_d;
  logic [7:0]  data_q, data_d;
  logic [15:0] crc_next;
  logic        accept;

  usbfs_crc16 u_crc16 (
    .crc_in  (crc_q),
    .byte_in (tp_byte),
    .crc_out (crc_next)
  );

  assign accept = tx_valid && tx_ready;

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    pid_d   = pid_q;
    cnt_d   = cnt_q;
    crc_d   = crc_q;
    data_d  = data_q;
    unique case (state_q)
      StIdle: begin
        if (tp_sta) begin
          pid_d = tp_pid;
          cnt_d = '0;
          crc_d = Crc16Init;
`ifdef USBFS_TX_SYNC_EN
          state_d = StSync;
`else
          state_d = StPid;
`endif
        end
      end
      StSync: if (accept) state_d = StPid;
      StPid: begin
        if (accept) state_d = is_data_pid(pid_q) ? StReq : StIdle;
      end
      StReq: state_d = StWait;
      StWait: begin
        if (tp_fin_n) begin
          data_d  = tp_byte;
          crc_d   = crc_next;
          cnt_d   = (cnt_q == MAX_DATA_LEN) ? cnt_q : cnt_q + 10'd1;
          state_d = StData;
        end else begin
          state_d = StCrcL;
        end
      end
      StData: begin
        if (accept) state_d = (cnt_q < MAX_DATA_LEN) ? StReq : StCrcL;
      end
      StCrcL: if (accept) state_d = StCrcH;
      StCrcH: if (accept) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from the registered state so they stay stable while stalled.
  always_comb begin
    tx_byte  = 8'h00;
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    unique case (state_q)
      StSync: begin
        tx_byte  = SyncByte;
        tx_valid = 1'b1;
      end
      StPid: begin
        tx_byte  = {~pid_q, pid_q};
        tx_valid = 1'b1;
        tx_last  = !is_data_pid(pid_q);
      end
      StData: begin
        tx_byte  = data_q;
        tx_valid = 1'b1;
      end
      StCrcL: begin
        tx_byte  = ~crc_q[7:0];
        tx_valid = 1'b1;
      end
      StCrcH: begin
        tx_byte  = ~crc_q[15:8];
        tx_valid = 1'b1;
        tx_last  = 1'b1;
      end
      default: ;
    endcase
  end

  // Gated by rstn so an aborted packet never fetches another byte while reset is held.
  assign tp_byte_req = (state_q == StReq) && rstn;
  assign tx_busy     = (state_q != StIdle);

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= StIdle;
      pid_q   <= 4'h0;
      cnt_q   <= 10'd0;
      crc_q   <= Crc16Init;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      pid_q   <= pid_d;
      cnt_q   <= cnt_d;
      crc_q   <= crc_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_usbfs_packet_tx.sv
// Directed self-checking bench for usbfs_packet_tx (default and MAX_DATA_LEN=4 instances).
module tb_usbfs_packet_tx;
  import usbfs_pkg::*;

`ifdef USBFS_TX_SYNC_EN
  localparam bit HasSync = 1'b1;
`else
  localparam bit HasSync = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       tp_sta = 1'b0;
  logic       tp_sta4 = 1'b0;
  logic [3:0] tp_pid = 4'h0;
  logic [7:0] tp_byte;
  logic       tp_fin_n;
  logic       tx_ready = 1'b1;

  logic       req_a, valid_a, last_a, busy_a;
  logic [7:0] byte_a;
  logic       req_b, valid_b, last_b, busy_b;
  logic [7:0] byte_b;

  always #5 clk = ~clk;

  usbfs_packet_tx u_dut (
    .clk         (clk),
    .rstn        (rstn),
    .tp_sta      (tp_sta),
    .tp_pid      (tp_pid),
    .tp_byte_req (req_a),
    .tp_byte     (tp_byte),
    .tp_fin_n    (tp_fin_n),
    .tx_byte     (byte_a),
    .tx_valid    (valid_a),
    .tx_ready    (tx_ready),
    .tx_last     (last_a),
    .tx_busy     (busy_a)
  );

  usbfs_packet_tx #(.MAX_DATA_LEN(10'd4)) u_dut4 (
    .clk         (clk),
    .rstn        (rstn),
    .tp_sta      (tp_sta4),
    .tp_pid      (tp_pid),
    .tp_byte_req (req_b),
    .tp_byte     (tp_byte),
    .tp_fin_n    (tp_fin_n),
    .tx_byte     (byte_b),
    .tx_valid    (valid_b),
    .tx_ready    (tx_ready),
    .tx_last     (last_b),
    .tx_busy     (busy_b)
  );

  // Monitored instance.
  logic       sel = 1'b0;
  logic       m_req, m_valid, m_last, m_busy;
  logic [7:0] m_byte;
  assign m_req   = sel ? req_b   : req_a;
  assign m_valid = sel ? valid_b : valid_a;
  assign m_last  = sel ? last_b  : last_a;
  assign m_busy  = sel ? busy_b  : busy_a;
  assign m_byte  = sel ? byte_b  : byte_a;

  int vectors = 0;
  int miscompares = 0;

  // Source model: answers request n (1-based since packet start) with src[n-1].
  logic [7:0] src [0:7];
  int         src_len = 0;
  int         req_cnt = 0;
  int         req_base = 0;
  int         rel;
  always_comb begin
    rel      = req_cnt - req_base;
    tp_byte  = 8'h00;
    tp_fin_n = 1'b0;
    if (rel >= 1 && rel <= src_len && rel <= 8) begin
      tp_byte  = src[rel-1];
      tp_fin_n = 1'b1;
    end
  end

  // Handshake monitor on the falling edge.
  logic [7:0] acc_q[$];
  logic       last_q[$];
  int         acc_base = 0;
  int         stall_err = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_byte = 8'h00;
  logic       prev_last = 1'b0;
  always @(negedge clk) begin
    if (m_req) req_cnt = req_cnt + 1;
    if (m_valid && tx_ready) begin
      acc_q.push_back(m_byte);
      last_q.push_back(m_last);
    end
    if (prev_stall && (!m_valid || m_byte !== prev_byte || m_last !== prev_last))
      stall_err = stall_err + 1;
    prev_stall = m_valid && !tx_ready;
    prev_byte  = m_byte;
    prev_last  = m_last;
  end

  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Golden CRC: non-reflected MSB-first register fed LSB-first bits, result bit-reversed.
  function automatic logic [15:0] crc_model(input int n);
    logic [15:0] c;
    logic [15:0] r;
    logic        fb;
    c = 16'hFFFF;
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 8; i++) begin
        fb = c[15] ^ src[k][i];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h8005;
      end
    end
    for (int i = 0; i < 16; i++) r[i] = c[15-i];
    return r;
  endfunction

  task automatic exp_start(input logic [3:0] pid);
    exp_q.delete();
    if (HasSync) exp_q.push_back(8'h80);
    exp_q.push_back({~pid, pid});
  endtask

  task automatic exp_data(input int n);
    logic [15:0] c;
    for (int k = 0; k < n; k++) exp_q.push_back(src[k]);
    c = crc_model(n);
    exp_q.push_back(~c[7:0]);
    exp_q.push_back(~c[15:8]);
  endtask

  task automatic check_seq(input string tag);
    chk({tag, "_len"}, acc_q.size() - acc_base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (acc_base + i < acc_q.size()) begin
        chk($sformatf("%s_byte%0d", tag, i), acc_q[acc_base+i], exp_q[i]);
        chk($sformatf("%s_last%0d", tag, i), last_q[acc_base+i], (i == exp_q.size() - 1));
      end
    end
  endtask

  task automatic start_pkt(input bit use4, input logic [3:0] pid);
    sel      = use4;
    req_base = req_cnt;
    acc_base = acc_q.size();
    tx_ready = 1'b1;
    @(posedge clk); #1;
    tp_pid = pid;
    if (use4) tp_sta4 = 1'b1; else tp_sta = 1'b1;
    @(posedge clk); #1;
    tp_sta  = 1'b0;
    tp_sta4 = 1'b0;
    chk("valid_rise", m_valid, 1);
    chk("busy_rise", m_busy, 1);
  endtask

  task automatic run_pkt(input bit use4, input logic [3:0] pid, input bit toggle,
                         input int extra_sta_at);
    bit done;
    start_pkt(use4, pid);
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      if (!m_busy) begin
        done = 1'b1;
      end else begin
        if (toggle) tx_ready = ~tx_ready;
        if (i == extra_sta_at) begin
          tp_pid = PidAck;
          if (use4) tp_sta4 = 1'b1; else tp_sta = 1'b1;
        end else begin
          tp_sta  = 1'b0;
          tp_sta4 = 1'b0;
        end
        @(posedge clk); #1;
      end
    end
    tp_sta   = 1'b0;
    tp_sta4  = 1'b0;
    tx_ready = 1'b1;
    chk("pkt_done", done, 1);
  endtask

  initial begin
    int pre;
    bit hit;
    pre = HasSync ? 2 : 1;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", valid_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_req", req_a, 0);
    chk("rst_byte", byte_a, 0);
    chk("rst_last", last_a, 0);
    chk("rst4_valid", valid_b, 0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // ACK handshake: single PID byte marked last.
    src_len = 0;
    exp_start(PidAck);
    run_pkt(1'b0, PidAck, 1'b0, -1);
    check_seq("ack");
    chk("ack_reqs", req_cnt - req_base, 0);
    chk("ack_busy_after", busy_a, 0);

    // Zero-length DATA1.
    src_len = 0;
    exp_start(PidData1);
    exp_data(0);
    run_pkt(1'b0, PidData1, 1'b0, -1);
    check_seq("zlp");
    chk("zlp_reqs", req_cnt - req_base, 1);

    // DATA0 06 00 01.
    src[0] = 8'h06; src[1] = 8'h00; src[2] = 8'h01;
    src_len = 3;
    exp_start(PidData0);
    exp_data(3);
    run_pkt(1'b0, PidData0, 1'b0, -1);
    check_seq("d0");
    chk("d0_reqs", req_cnt - req_base, 4);

    // DATA1 with back-pressure toggling every cycle.
    src[0] = 8'hA5; src[1] = 8'h5A; src[2] = 8'hFF; src[3] = 8'h3C;
    src_len = 4;
    exp_start(PidData1);
    exp_data(4);
    run_pkt(1'b0, PidData1, 1'b0, -1);
    check_seq("d1_ready");
    run_pkt(1'b0, PidData1, 1'b1, -1);
    check_seq("d1_toggle");
    chk("d1_stall_stable", stall_err, 0);

    // MAX_DATA_LEN=4 against an 8-byte source, with a stray tp_sta mid-packet.
    for (int k = 0; k < 8; k++) src[k] = 8'(8'h11 * (k + 1));
    src_len = 8;
    exp_start(PidData0);
    exp_data(4);
    run_pkt(1'b1, PidData0, 1'b0, 3);
    check_seq("max4");
    chk("max4_reqs", req_cnt - req_base, 4);
    repeat (3) @(posedge clk);
    #1;
    chk("max4_idle_after", busy_b, 0);
    chk("max4_no_extra", acc_q.size() - acc_base, exp_q.size());

    // Reset after the third payload byte.
    sel = 1'b0;
    for (int k = 0; k < 5; k++) src[k] = 8'(8'h10 * (k + 1));
    src_len = 5;
    start_pkt(1'b0, PidData0);
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      if (acc_q.size() - acc_base >= pre + 3) hit = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("rstmid_reached", hit, 1);
    rstn = 1'b0;
    @(posedge clk); #1;
    chk("rstmid_valid", valid_a, 0);
    chk("rstmid_byte", byte_a, 0);
    chk("rstmid_last", last_a, 0);
    chk("rstmid_busy", busy_a, 0);
    chk("rstmid_req", req_a, 0);
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_req_after", req_a, 0);
    @(posedge clk); #1;
    chk("rstmid_reqs", req_cnt - req_base, 3);
    chk("rstmid_bytes", acc_q.size() - acc_base, pre + 3);

    // Fresh NAK after the abort.
    src_len = 0;
    exp_start(PidNak);
    run_pkt(1'b0, PidNak, 1'b0, -1);
    check_seq("nak");
    chk("nak_busy_after", busy_a, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
